// File: rtl/pipeline_pkg.sv
// Shared pipeline types: multi-cycle unit FSM states and EX operand forward selects.
// Pure declarations; no latency, no backpressure.
package pipeline_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with the hazard unit.
// Wiring only; no latency, no backpressure.
interface hazard_ctrl_if;
    import pipeline_pkg::*;

    logic [4:0] rs_id5, rt_id5;
    logic [4:0] rs_oe5, rt_oe5;
    logic [4:0] write_reg_ex5, write_reg_mem5, write_reg_wb5;
    logic       enable_wreg_ex, enable_wreg_mem, enable_wreg_wb;
    logic       mem_to_reg_ex, mem_to_reg_mem;
    logic       branch_id, pc_src_id;
    logic       md_start_ex;

    logic       stall_if, stall_id, stall_ex;
    logic       flush_ex, flush_id;
    fwd_sel_t   forward_a_ex2, forward_b_ex2;
    logic       forward_a_id, forward_b_id;
    logic       md_busy_o, md_done_o;

    // Pipeline side drives the hazard inputs and consumes the controls.
    modport master (
        output rs_id5, rt_id5, rs_oe5, rt_oe5,
               write_reg_ex5, write_reg_mem5, write_reg_wb5,
               enable_wreg_ex, enable_wreg_mem, enable_wreg_wb,
               mem_to_reg_ex, mem_to_reg_mem, branch_id, pc_src_id, md_start_ex,
        input  stall_if, stall_id, stall_ex, flush_ex, flush_id,
               forward_a_ex2, forward_b_ex2, forward_a_id, forward_b_id,
               md_busy_o, md_done_o
    );

    modport slave (
        input  rs_id5, rt_id5, rs_oe5, rt_oe5,
               write_reg_ex5, write_reg_mem5, write_reg_wb5,
               enable_wreg_ex, enable_wreg_mem, enable_wreg_wb,
               mem_to_reg_ex, mem_to_reg_mem, branch_id, pc_src_id, md_start_ex,
        output stall_if, stall_id, stall_ex, flush_ex, flush_id,
               forward_a_ex2, forward_b_ex2, forward_a_id, forward_b_id,
               md_busy_o, md_done_o
    );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load/branch stalls, multi-cycle EX hold.
// Stalls/flushes/forwards are zero-latency combinational; md_busy_o/md_done_o come from the FSM registers.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] rs_id5,
    input  logic [4:0] rt_id5,
    input  logic [4:0] rs_oe5,
    input  logic [4:0] rt_oe5,
    input  logic [4:0] write_reg_ex5,
    input  logic [4:0] write_reg_mem5,
    input  logic [4:0] write_reg_wb5,
    input  logic       enable_wreg_ex,
    input  logic       enable_wreg_mem,
    input  logic       enable_wreg_wb,
    input  logic       mem_to_reg_ex,
    input  logic       mem_to_reg_mem,
    input  logic       branch_id,
    input  logic       pc_src_id,
    input  logic       md_start_ex,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       flush_ex,
    output logic       flush_id,
    output fwd_sel_t   forward_a_ex2,
    output fwd_sel_t   forward_b_ex2,
    output logic       forward_a_id,
    output logic       forward_b_id,
    output logic       md_busy_o,
    output logic       md_done_o
);

    // MEM result wins over WB; register 0 is never forwarded.
    function automatic fwd_sel_t fwd_sel(
        input logic       en_mem,
        input logic [4:0] wr_mem,
        input logic       en_wb,
        input logic [4:0] wr_wb,
        input logic [4:0] src
    );
        if (en_mem && (wr_mem != 5'd0) && (wr_mem == src)) begin
            return FWD_MEM;
        end else if (en_wb && (wr_wb != 5'd0) && (wr_wb == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    md_state_t             r_state;
    logic [MD_CNT_W-1:0]   r_cnt;
    logic                  r_md_busy;
    logic                  r_md_done;

    fwd_sel_t w_fwd_a_id_sel;
    fwd_sel_t w_fwd_b_id_sel;
    logic     w_ex_hit_rs, w_ex_hit_rt;
    logic     w_mem_ld_hit_rs, w_mem_ld_hit_rt;
    logic     w_lwstall, w_brstall, w_hazard;
    logic     w_md_hold;

    assign forward_a_ex2  = fwd_sel(enable_wreg_mem, write_reg_mem5, enable_wreg_wb, write_reg_wb5, rs_oe5);
    assign forward_b_ex2  = fwd_sel(enable_wreg_mem, write_reg_mem5, enable_wreg_wb, write_reg_wb5, rt_oe5);
    assign w_fwd_a_id_sel = fwd_sel(enable_wreg_mem, write_reg_mem5, 1'b0, 5'd0, rs_id5);
    assign w_fwd_b_id_sel = fwd_sel(enable_wreg_mem, write_reg_mem5, 1'b0, 5'd0, rt_id5);
    assign forward_a_id   = (w_fwd_a_id_sel == FWD_MEM);
    assign forward_b_id   = (w_fwd_b_id_sel == FWD_MEM);

    assign w_ex_hit_rs     = enable_wreg_ex && (write_reg_ex5 != 5'd0) && (write_reg_ex5 == rs_id5);
    assign w_ex_hit_rt     = enable_wreg_ex && (write_reg_ex5 != 5'd0) && (write_reg_ex5 == rt_id5);
    assign w_mem_ld_hit_rs = mem_to_reg_mem && (write_reg_mem5 != 5'd0) && (write_reg_mem5 == rs_id5);
    assign w_mem_ld_hit_rt = mem_to_reg_mem && (write_reg_mem5 != 5'd0) && (write_reg_mem5 == rt_id5);

    assign w_lwstall = mem_to_reg_ex && (w_ex_hit_rs || w_ex_hit_rt);
    assign w_brstall = branch_id && (w_ex_hit_rs || w_ex_hit_rt || w_mem_ld_hit_rs || w_mem_ld_hit_rt);
    assign w_hazard  = w_lwstall || w_brstall;

    // The start cycle stalls too, so the whole op costs exactly MD_CYCLES stall cycles.
    assign w_md_hold = ((r_state == MD_IDLE) && md_start_ex) || (r_state == MD_BUSY);

    assign stall_if  = w_md_hold || w_hazard;
    assign stall_id  = w_md_hold || w_hazard;
    assign stall_ex  = w_md_hold;
    assign flush_ex  = !w_md_hold && w_hazard;
    assign flush_id  = pc_src_id && !stall_id;
    assign md_busy_o = r_md_busy;
    assign md_done_o = r_md_done;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (md_start_ex) begin
                        r_state   <= MD_BUSY;
                        r_cnt     <= MD_CNT_W'(MD_CYCLES - 2);
                        r_md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state   <= MD_DONE;
                        r_md_busy <= 1'b0;
                        r_md_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                MD_DONE: begin
                    r_state   <= MD_IDLE;
                    r_md_done <= 1'b0;
                end
                default: begin
                    r_state   <= MD_IDLE;
                    r_cnt     <= '0;
                    r_md_busy <= 1'b0;
                    r_md_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
